sram_like_master: RTL and testbench



---
 rtl/sram_like_master.sv | 147 ++++++++++++++
 tb/tb_sram_like_master.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/sram_like_master.sv
// Single-channel sram-like bus master: turns one pipeline-stage access into a
// req/addr_ok/data_ok transaction, stalls the stage and holds the result.
module sram_like_master #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_wr,
    input  logic [1:0]        cpu_size,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_flush,
    input  logic              pipe_stall,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_valid,
    output logic              stall_out,
    output logic              req,
    output logic              wr,
    output logic [1:0]        size,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata,
    input  logic              addr_ok,
    input  logic              data_ok,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t            state_reg;
    logic              discard_reg;
    logic              req_reg;
    logic              wr_reg;
    logic [1:0]        size_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [DATA_W-1:0] cpu_rdata_reg;
    logic              cpu_valid_reg;
    logic [CNT_W-1:0]  stall_cnt_reg;
    logic              stall_next;
    logic              kill;

    // A response is thrown away if the access was flushed earlier or is being
    // flushed in the very cycle the data arrives.
    assign kill = discard_reg | cpu_flush;

    always_comb begin
        stall_next = 1'b0;
        unique case (state_reg)
            IDLE:     stall_next = cpu_req & ~cpu_flush;
            REQ:      stall_next = ~kill;
            WAIT:     stall_next = ~kill;
            default:  stall_next = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            discard_reg   <= 1'b0;
            req_reg       <= 1'b0;
            wr_reg        <= 1'b0;
            size_reg      <= 2'd0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            cpu_rdata_reg <= '0;
            cpu_valid_reg <= 1'b0;
            stall_cnt_reg <= '0;
        end else begin
            if (stall_next && (stall_cnt_reg != '1))
                stall_cnt_reg <= stall_cnt_reg + CNT_ONE;

            unique case (state_reg)
                IDLE: begin
                    if (cpu_req && !cpu_flush) begin
                        wr_reg    <= cpu_wr;
                        size_reg  <= cpu_size;
                        addr_reg  <= cpu_addr;
                        wdata_reg <= cpu_wdata;
                        req_reg   <= 1'b1;
                        state_reg <= REQ;
                    end
                end
                REQ: begin
                    // req stays up until accepted, flush only marks the access dead
                    if (cpu_flush)
                        discard_reg <= 1'b1;
                    if (addr_ok) begin
                        req_reg <= 1'b0;
                        if (!data_ok) begin
                            state_reg <= WAIT;
                        end else if (kill) begin
                            discard_reg <= 1'b0;
                            state_reg   <= IDLE;
                        end else begin
                            cpu_rdata_reg <= rdata;
                            cpu_valid_reg <= 1'b1;
                            state_reg     <= DONE;
                        end
                    end
                end
                WAIT: begin
                    if (cpu_flush)
                        discard_reg <= 1'b1;
                    if (data_ok) begin
                        if (kill) begin
                            discard_reg <= 1'b0;
                            state_reg   <= IDLE;
                        end else begin
                            cpu_rdata_reg <= rdata;
                            cpu_valid_reg <= 1'b1;
                            state_reg     <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (cpu_flush || !pipe_stall) begin
                        cpu_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign stall_out = stall_next;
    assign req       = req_reg;
    assign wr        = wr_reg;
    assign size      = size_reg;
    assign addr      = addr_reg;
    assign wdata     = wdata_reg;
    assign cpu_rdata = cpu_rdata_reg;
    assign cpu_valid = cpu_valid_reg;
    assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_sram_like_master.sv
// Directed bench for sram_like_master: read, combined handshake, slow slave,
// flush, write, reset mid-transaction and stall-counter saturation.
module tb_sram_like_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req;
    logic        cpu_wr;
    logic [1:0]  cpu_size;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_flush;
    logic        pipe_stall;
    logic [31:0] rdata;
    logic        addr_ok;
    logic        data_ok;

    logic [31:0] cpu_rdata;
    logic        cpu_valid;
    logic        stall_out;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] stall_cnt;

    logic [31:0] s_cpu_rdata;
    logic        s_cpu_valid;
    logic        s_stall_out;
    logic        s_req;
    logic        s_wr;
    logic [1:0]  s_size;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic [2:0]  s_stall_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram_like_master dut (
        .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_size(cpu_size),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_flush(cpu_flush),
        .pipe_stall(pipe_stall), .cpu_rdata(cpu_rdata), .cpu_valid(cpu_valid),
        .stall_out(stall_out), .req(req), .wr(wr), .size(size), .addr(addr),
        .wdata(wdata), .rdata(rdata), .addr_ok(addr_ok), .data_ok(data_ok),
        .stall_cnt(stall_cnt)
    );

    sram_like_master #(.ADDR_W(32), .DATA_W(32), .CNT_W(3)) dut_sat (
        .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_size(cpu_size),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_flush(cpu_flush),
        .pipe_stall(pipe_stall), .cpu_rdata(s_cpu_rdata), .cpu_valid(s_cpu_valid),
        .stall_out(s_stall_out), .req(s_req), .wr(s_wr), .size(s_size), .addr(s_addr),
        .wdata(s_wdata), .rdata(rdata), .addr_ok(addr_ok), .data_ok(data_ok),
        .stall_cnt(s_stall_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; cpu_req = 1'b0; cpu_wr = 1'b0; cpu_size = 2'd0;
        cpu_addr = '0; cpu_wdata = '0; cpu_flush = 1'b0; pipe_stall = 1'b0;
        rdata = '0; addr_ok = 1'b0; data_ok = 1'b0;
        repeat (2) tick();
        check("rst_req", {31'd0, req}, 32'd0);
        check("rst_valid", {31'd0, cpu_valid}, 32'd0);
        check("rst_stall_out", {31'd0, stall_out}, 32'd0);
        check("rst_addr", addr, 32'd0);
        check("rst_rdata", cpu_rdata, 32'd0);
        check("rst_cnt", stall_cnt, 32'd0);
        rst = 1'b0;
        tick();

        // read hit with a one-cycle slave
        cpu_req = 1'b1; cpu_addr = 32'hBFC00000; cpu_size = 2'd2; #1;
        check("rd_idle_stall", {31'd0, stall_out}, 32'd1);
        tick();
        cpu_req = 1'b0;
        check("rd_req", {31'd0, req}, 32'd1);
        check("rd_addr", addr, 32'hBFC00000);
        addr_ok = 1'b1; #1;
        check("rd_req_stall", {31'd0, stall_out}, 32'd1);
        tick();
        addr_ok = 1'b0;
        check("rd_wait_req", {31'd0, req}, 32'd0);
        check("rd_wait_stall", {31'd0, stall_out}, 32'd1);
        data_ok = 1'b1; rdata = 32'h3C1D0001;
        tick();
        data_ok = 1'b0;
        check("rd_valid", {31'd0, cpu_valid}, 32'd1);
        check("rd_rdata", cpu_rdata, 32'h3C1D0001);
        check("rd_done_stall", {31'd0, stall_out}, 32'd0);
        check("rd_cnt", stall_cnt, 32'd3);
        tick();
        check("rd_idle_valid", {31'd0, cpu_valid}, 32'd0);

        // addr_ok and data_ok together: result one cycle after REQ
        cpu_req = 1'b1; cpu_addr = 32'h00001000;
        tick();
        cpu_req = 1'b0;
        addr_ok = 1'b1; data_ok = 1'b1; rdata = 32'h11223344;
        tick();
        addr_ok = 1'b0; data_ok = 1'b0;
        check("comb_valid", {31'd0, cpu_valid}, 32'd1);
        check("comb_rdata", cpu_rdata, 32'h11223344);
        check("comb_req", {31'd0, req}, 32'd0);
        check("comb_cnt", stall_cnt, 32'd5);
        tick();

        // slow slave, bus fields held while cpu_* inputs change
        cpu_req = 1'b1; cpu_addr = 32'h00002002; cpu_size = 2'd1; cpu_wdata = 32'h55AA55AA;
        tick();
        cpu_req = 1'b0; cpu_addr = 32'hFFFFFFFF; cpu_size = 2'd3; cpu_wdata = 32'h0;
        for (int i = 0; i < 4; i++) begin
            check("slow_req", {31'd0, req}, 32'd1);
            check("slow_addr", addr, 32'h00002002);
            check("slow_size", {30'd0, size}, 32'd1);
            check("slow_wdata", wdata, 32'h55AA55AA);
            tick();
        end
        addr_ok = 1'b1;
        tick();
        addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'hCAFEF00D; pipe_stall = 1'b1;
        tick();
        data_ok = 1'b0;
        check("slow_cnt", stall_cnt, 32'd12);
        for (int i = 0; i < 3; i++) begin
            check("hold_valid", {31'd0, cpu_valid}, 32'd1);
            check("hold_rdata", cpu_rdata, 32'hCAFEF00D);
            if (i == 2) pipe_stall = 1'b0;
            tick();
        end
        check("hold_release", {31'd0, cpu_valid}, 32'd0);

        // flush while waiting for data
        cpu_req = 1'b1; cpu_addr = 32'h00003000; cpu_size = 2'd2;
        tick();
        cpu_req = 1'b0; addr_ok = 1'b1;
        tick();
        addr_ok = 1'b0; cpu_flush = 1'b1; #1;
        check("fl_stall_flush", {31'd0, stall_out}, 32'd0);
        tick();
        cpu_flush = 1'b0;
        check("fl_stall_drain", {31'd0, stall_out}, 32'd0);
        check("fl_valid_drain", {31'd0, cpu_valid}, 32'd0);
        tick();
        data_ok = 1'b1; rdata = 32'hDEADBEEF; #1;
        check("fl_stall_data", {31'd0, stall_out}, 32'd0);
        tick();
        data_ok = 1'b0;
        check("fl_valid", {31'd0, cpu_valid}, 32'd0);
        check("fl_rdata", cpu_rdata, 32'hCAFEF00D);
        check("fl_cnt", stall_cnt, 32'd14);

        // byte write; back in IDLE so the new request stalls at once
        cpu_req = 1'b1; cpu_wr = 1'b1; cpu_size = 2'd0; cpu_addr = 32'h00000003;
        cpu_wdata = 32'h000000AB; #1;
        check("wr_idle_stall", {31'd0, stall_out}, 32'd1);
        tick();
        cpu_req = 1'b0; cpu_wr = 1'b0;
        check("wr_wr", {31'd0, wr}, 32'd1);
        check("wr_size", {30'd0, size}, 32'd0);
        check("wr_addr", addr, 32'h00000003);
        check("wr_wdata", wdata, 32'h000000AB);
        addr_ok = 1'b1;
        tick();
        addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'h0;
        tick();
        data_ok = 1'b0;
        check("wr_valid", {31'd0, cpu_valid}, 32'd1);
        check("wr_cnt", stall_cnt, 32'd17);
        // flush in DONE overrides pipe_stall
        cpu_flush = 1'b1; pipe_stall = 1'b1;
        tick();
        cpu_flush = 1'b0; pipe_stall = 1'b0;
        check("done_flush_valid", {31'd0, cpu_valid}, 32'd0);

        // reset in WAIT, then a stray data_ok
        cpu_req = 1'b1; cpu_addr = 32'h00004000; cpu_size = 2'd2;
        tick();
        cpu_req = 1'b0; addr_ok = 1'b1;
        tick();
        addr_ok = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstw_req", {31'd0, req}, 32'd0);
        data_ok = 1'b1; rdata = 32'h99999999; #1;
        check("rstw_stall", {31'd0, stall_out}, 32'd0);
        tick();
        data_ok = 1'b0;
        check("rstw_valid", {31'd0, cpu_valid}, 32'd0);
        check("rstw_rdata", cpu_rdata, 32'h0);
        check("rstw_req2", {31'd0, req}, 32'd0);
        check("rstw_cnt", stall_cnt, 32'd0);

        // ten stalled cycles: 32-bit counter reads 10, 3-bit counter saturates at 7
        cpu_req = 1'b1; cpu_addr = 32'h00005000;
        tick();
        cpu_req = 1'b0;
        repeat (9) tick();
        check("sat_cnt32", stall_cnt, 32'd10);
        check("sat_cnt3", {29'd0, s_stall_cnt}, 32'd7);
        addr_ok = 1'b1; data_ok = 1'b1; rdata = 32'h0BADF00D;
        tick();
        addr_ok = 1'b0; data_ok = 1'b0;
        check("sat_valid", {31'd0, cpu_valid}, 32'd1);
        check("sat_cnt3_hold", {29'd0, s_stall_cnt}, 32'd7);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
